// File: rtl/port_bank_pkg.sv
// Shared parameters and helpers for the port_bank I/O block.
// Holds the default sizes, the select-width function and the packed-bit index helper.
package port_bank_pkg;

    localparam int DEF_NUM_PORTS   = 3;
    localparam int DEF_PORT_WIDTH  = 8;
    localparam int DEF_SYNC_STAGES = 2;

    function automatic int selWidth(input int numPorts);
        return (numPorts > 1) ? $clog2(numPorts) : 1;
    endfunction

    function automatic int bitIndex(input int port, input int width, input int bitPos);
        return port * width + bitPos;
    endfunction

endpackage

// File: rtl/port_bank_sync.sv
// Single-bit input synchronizer used by port_bank for every pad bit.
// Depth is SYNC_STAGES flops; q is the last stage, cleared by synchronous rst.
module port_sync
    import port_bank_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/port_bank.sv
// GPIO port bank: per-port TRIS/LAT registers, synchronized pad inputs, read mux.
// Optional interrupt-on-change logic and ports are compiled in with macro PORT_IOC_EN.
module port_bank
    import port_bank_pkg::*;
#(
    parameter int NUM_PORTS   = DEF_NUM_PORTS,
    parameter int PORT_WIDTH  = DEF_PORT_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [selWidth(NUM_PORTS)-1:0]   port_sel,
    input  logic [PORT_WIDTH-1:0]            wr_data,
    input  logic                             tris_we,
    input  logic                             lat_we,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0]  pin_in,
    output logic [NUM_PORTS*PORT_WIDTH-1:0]  pin_out,
    output logic [NUM_PORTS*PORT_WIDTH-1:0]  pin_oe,
`ifdef PORT_IOC_EN
    input  logic                             ioc_mask_we,
    input  logic                             ioc_clr,
    output logic [NUM_PORTS-1:0]             ioc_flag,
    output logic                             ioc_irq,
`endif
    output logic [PORT_WIDTH-1:0]            rd_data
);

    localparam int SEL_W = selWidth(NUM_PORTS);
    localparam int TOTAL = NUM_PORTS * PORT_WIDTH;

    logic [PORT_WIDTH-1:0] trisReg  [NUM_PORTS];
    logic [PORT_WIDTH-1:0] latReg   [NUM_PORTS];
    logic [PORT_WIDTH-1:0] syncPort [NUM_PORTS];
    logic [TOTAL-1:0]      syncFlat;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
        for (genvar b = 0; b < PORT_WIDTH; b++) begin : gBit
            localparam int IDX = bitIndex(p, PORT_WIDTH, b);
            port_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
                .clk (clk),
                .rst (rst),
                .d   (pin_in[IDX]),
                .q   (syncFlat[IDX])
            );
        end
        assign syncPort[p] = syncFlat[p*PORT_WIDTH +: PORT_WIDTH];
    end

    // A port_sel beyond the last port matches no loop index, so such writes fall away.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                trisReg[p] <= '1;
                latReg[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (port_sel == SEL_W'(p)) begin
                    if (tris_we) trisReg[p] <= wr_data;
                    if (lat_we)  latReg[p]  <= wr_data;
                end
            end
        end
    end

    always_comb begin
        pin_out = '0;
        pin_oe  = '0;
        rd_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            pin_out[p*PORT_WIDTH +: PORT_WIDTH] = latReg[p];
            pin_oe[p*PORT_WIDTH +: PORT_WIDTH]  = ~trisReg[p];
            if (port_sel == SEL_W'(p)) begin
                rd_data = (trisReg[p] & syncPort[p]) | (~trisReg[p] & latReg[p]);
            end
        end
    end

`ifdef PORT_IOC_EN
    localparam int ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    logic [PORT_WIDTH-1:0] maskReg [NUM_PORTS];
    logic [PORT_WIDTH-1:0] prevReg [NUM_PORTS];
    logic [NUM_PORTS-1:0]  flagReg;
    logic [NUM_PORTS-1:0]  flagSet;
    logic [ARM_W-1:0]      armCnt;
    logic                  armed;

    // Arming hides the synchronizer flush after reset from the change detector.
    assign armed = (armCnt == ARM_DONE);

    always_comb begin
        flagSet = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            flagSet[p] = armed && (|((syncPort[p] ^ prevReg[p]) & maskReg[p] & trisReg[p]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armCnt  <= '0;
            flagReg <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                maskReg[p] <= '0;
                prevReg[p] <= '0;
            end
        end else begin
            if (!armed) armCnt <= armCnt + ARM_W'(1);
            for (int p = 0; p < NUM_PORTS; p++) begin
                prevReg[p] <= syncPort[p];
                if (ioc_mask_we && (port_sel == SEL_W'(p))) maskReg[p] <= wr_data;
                if (flagSet[p]) begin
                    flagReg[p] <= 1'b1;
                end else if (ioc_clr && (port_sel == SEL_W'(p))) begin
                    flagReg[p] <= 1'b0;
                end
            end
        end
    end

    assign ioc_flag = flagReg;
    assign ioc_irq  = |flagReg;
`endif

endmodule

// File: doc/port_bank.md
PORT_BANK -- requirements
Module: port_bank

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of I/O ports (1..8).
REQ-002 SHALL have parameter PORT_WIDTH, default 8, bits per port (1..16).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (2..4).
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port port_sel  in  SEL_W=max(1,clog2(NUM_PORTS))  target port for writes, reads and IOC clears.
REQ-007 SHALL have port wr_data  in  PORT_WIDTH  write data (from W).
REQ-008 SHALL have port tris_we  in  1  write wr_data to TRIS[port_sel].
REQ-009 SHALL have port lat_we  in  1  write wr_data to output latch LAT[port_sel].
REQ-010 SHALL have port pin_in  in  NUM_PORTS*PORT_WIDTH  raw pad inputs, port p at bits [p*PORT_WIDTH +: PORT_WIDTH].
REQ-011 SHALL have port pin_out  out  NUM_PORTS*PORT_WIDTH  LAT contents, same packing.
REQ-012 SHALL have port pin_oe  out  NUM_PORTS*PORT_WIDTH  pad drive enable = ~TRIS, same packing.
REQ-013 SHALL have port rd_data  out  PORT_WIDTH  read value of port_sel.
REQ-014 SHALL have ports ioc_mask_we in 1, ioc_clr in 1, ioc_flag out NUM_PORTS, ioc_irq out 1 (present only with PORT_IOC_EN).

Function
REQ-015 SHALL register each pin_in bit through SYNC_STAGES flops; SYNC[p] is the last stage.
REQ-016 SHALL make rd_data combinational: bit b = TRIS[port_sel][b] ? SYNC[port_sel][b] : LAT[port_sel][b].
REQ-017 SHALL give pin change-to-rd_data latency of exactly SYNC_STAGES cycles for input bits.
REQ-018 SHALL update TRIS/LAT on the edge where tris_we/lat_we is high; tris_we and lat_we together update both.
REQ-019 SHALL ignore writes and clears with port_sel >= NUM_PORTS and drive rd_data = 0 for such port_sel.
REQ-020 SHALL reflect a TRIS/LAT write on pin_oe/pin_out/rd_data the cycle after the write edge.

Reset
REQ-021 SHALL on rst: TRIS = all ones (all inputs), LAT = 0, sync flops = 0, pin_oe = 0, pin_out = 0.
REQ-022 SHALL give rst priority over every write, set and clear in the same cycle, including mid-operation.
REQ-023 SHALL (with PORT_IOC_EN) reset MASK = 0, PREV = 0, ioc_flag = 0, ioc_irq = 0, arm counter = 0.

Configuration
REQ-024 SHALL compile interrupt-on-change only when macro PORT_IOC_EN is defined.
REQ-025 With PORT_IOC_EN: ioc_mask_we writes wr_data to MASK[port_sel]; PREV[p] <= SYNC[p] each cycle.
REQ-026 With PORT_IOC_EN: ioc_flag[p] sets when armed and |((SYNC[p]^PREV[p]) & MASK[p] & TRIS[p]); output bits never trigger.
REQ-027 With PORT_IOC_EN: ioc_clr clears ioc_flag[port_sel]; a set condition in the same cycle wins (flag stays 1).
REQ-028 With PORT_IOC_EN: arm counter counts SYNC_STAGES+1 cycles after rst deasserts; no flag sets before armed.
REQ-029 With PORT_IOC_EN: ioc_irq = |ioc_flag, combinational.
REQ-030 Without PORT_IOC_EN: no MASK/PREV/flag/counter logic, and the ioc ports are absent.

Structure
REQ-031 SHALL place parameter defaults, the SEL_W function and the packed-index helper in shared package port_bank_pkg.
REQ-032 SHALL implement the per-bit synchronizer as sub-module port_sync (param SYNC_STAGES), one instance per bit.

Verification
REQ-033 Reset then tris_we=1, port_sel=1, wr_data=8'hF0 -> next cycle pin_oe port1 = 8'h0F, other ports 8'h00.
REQ-034 TRIS1=8'hF0, LAT1=8'hA5, pin_in port1=8'h3C, port_sel=1 -> rd_data=8'h35 exactly SYNC_STAGES cycles after pins settle.
REQ-035 port_sel=3 with NUM_PORTS=3, tris_we=lat_we=1 -> no state change, rd_data=0.
REQ-036 PORT_IOC_EN, MASK0=8'h01, pin0 bit0 toggles -> ioc_flag[0]=1 and ioc_irq=1 SYNC_STAGES+1 cycles later; toggling masked-off bit7 -> no flag.
REQ-037 PORT_IOC_EN, ioc_clr on the same cycle as a new change on port0 -> ioc_flag[0] stays 1; ioc_clr alone -> flag 0 next cycle.
REQ-038 rst asserted while flags set and pins toggling -> all outputs at reset values next cycle; no flag within SYNC_STAGES+1 cycles after release.
